// File: rtl/regfile_nzcv.sv
// Conditional-execution register file: 16 general-purpose registers with
// combinational read ports and write-to-read bypass, an NZCV status register,
// an ARM-style condition-code evaluator gating both writes and flag updates,
// and a wrapping count of committed register writes.
module regfile_nzcv #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Read ports
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  // Write port
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  // Flags and condition
  input  logic              set_flags,
  input  logic [3:0]        nzcv_in,
  input  logic [3:0]        cond,
  output logic              cond_pass,
  output logic [3:0]        flags_out,
  output logic              carry_out,
  output logic [15:0]       commit_count
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  // Condition code encodings
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  logic [DATA_W-1:0]  regs_q [NumRegs];
  logic [3:0]         flags_q;
  logic [15:0]        count_q;
  logic [15:0]        count_d;

  logic               flag_n;
  logic               flag_z;
  logic               flag_c;
  logic               flag_v;
  logic               pass;
  logic               wr_commit;
  logic               flags_commit;
  logic [NumRegs-1:0] wr_onehot;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluate the condition against the flags held before this edge only;
  // nzcv_in never feeds this path, so set-and-test sees the old flags.
  always_comb begin
    pass = 1'b0;
    unique case (cond)
      CondEq:  pass = flag_z;
      CondNe:  pass = ~flag_z;
      CondCs:  pass = flag_c;
      CondCc:  pass = ~flag_c;
      CondMi:  pass = flag_n;
      CondPl:  pass = ~flag_n;
      CondVs:  pass = flag_v;
      CondVc:  pass = ~flag_v;
      CondHi:  pass = flag_c & ~flag_z;
      CondLs:  pass = ~flag_c | flag_z;
      CondGe:  pass = (flag_n == flag_v);
      CondLt:  pass = (flag_n != flag_v);
      CondGt:  pass = ~flag_z & (flag_n == flag_v);
      CondLe:  pass = flag_z | (flag_n != flag_v);
      CondAl:  pass = 1'b1;
      CondNv:  pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  assign cond_pass = pass;

  // Reset discards any write or flag update presented in the same cycle.
  assign wr_commit    = wr_en & pass & ~reset;
  assign flags_commit = set_flags & pass & ~reset;

  // Decode the write address into per-register enables.
  always_comb begin
    wr_onehot = '0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      wr_onehot[i] = wr_commit && (wr_addr == ADDR_W'(i));
    end
  end

  // Register array: synchronous clear, otherwise load the enabled entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        if (wr_onehot[i]) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  // Read ports: a committing write to the same address is forwarded.
  always_comb begin
    a_out = regs_q[ra_addr];
    b_out = regs_q[rb_addr];
    if (wr_commit && (ra_addr == wr_addr)) begin
      a_out = wr_data;
    end
    if (wr_commit && (rb_addr == wr_addr)) begin
      b_out = wr_data;
    end
  end

  // Status register: loads independently of the register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flags_commit) begin
      flags_q <= nzcv_in;
    end
  end

  assign flags_out = flags_q;
  assign carry_out = flags_q[1];

  // Commit counter next state; wraps naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if (wr_commit) begin
      count_d = count_q + 16'd1;
    end
  end

  // Commit counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign commit_count = count_q;

endmodule

// File: tb/tb_regfile_nzcv.sv
// Directed bench for regfile_nzcv with an architectural model checked every cycle.
module tb_regfile_nzcv;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ra_addr, rb_addr, wr_addr;
  logic [31:0] a_out, b_out, wr_data;
  logic        wr_en, set_flags, cond_pass, carry_out;
  logic [3:0]  nzcv_in, cond, flags_out;
  logic [15:0] commit_count;

  int errors = 0;
  int checks = 0;

  // Architectural model
  logic [31:0] m_regs [16];
  logic [3:0]  m_flags;
  int          m_count;
  bit          m_valid = 0;

  always #5 clk = ~clk;

  regfile_nzcv #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .a_out(a_out), .b_out(b_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .set_flags(set_flags), .nzcv_in(nzcv_in), .cond(cond),
    .cond_pass(cond_pass), .flags_out(flags_out), .carry_out(carry_out),
    .commit_count(commit_count)
  );

  function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare all outputs against the model (at negedge, inputs settled).
  task automatic settle();
    bit          commit;
    logic [31:0] ea, eb;
    @(negedge clk);
    if (m_valid) begin
      commit = !reset && wr_en && m_pass(cond, m_flags);
      ea = (commit && ra_addr == wr_addr) ? wr_data : m_regs[ra_addr];
      eb = (commit && rb_addr == wr_addr) ? wr_data : m_regs[rb_addr];
      chk("model_a_out", a_out, ea);
      chk("model_b_out", b_out, eb);
      chk("model_cond_pass", {31'd0, cond_pass}, {31'd0, m_pass(cond, m_flags)});
      chk("model_flags", {28'd0, flags_out}, {28'd0, m_flags});
      chk("model_carry", {31'd0, carry_out}, {31'd0, m_flags[1]});
      chk("model_count", {16'd0, commit_count}, m_count);
    end
  endtask

  // Advance one rising edge and apply the same rules to the model.
  task automatic edge_();
    bit p;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_flags = 4'b0000;
      m_count = 0;
      m_valid = 1;
    end else begin
      p = m_pass(cond, m_flags);
      if (wr_en && p) begin
        m_regs[wr_addr] = wr_data;
        m_count = (m_count + 1) % 65536;
      end
      if (set_flags && p) m_flags = nzcv_in;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    edge_();
  endtask

  initial begin
    reset = 1; wr_en = 0; set_flags = 0; wr_addr = 0; wr_data = 0;
    ra_addr = 0; rb_addr = 0; nzcv_in = 0; cond = 4'b1110;
    cyc(); cyc();

    // Post-reset state
    reset = 0; cond = 4'b0001; ra_addr = 9; rb_addr = 15;
    settle();
    chk("rst_a_out", a_out, 32'h0);
    chk("rst_b_out", b_out, 32'h0);
    chk("rst_flags", {28'd0, flags_out}, 32'h0);
    chk("rst_carry", {31'd0, carry_out}, 32'h0);
    chk("rst_count", {16'd0, commit_count}, 32'h0);
    chk("rst_cond_ne", {31'd0, cond_pass}, 32'h1);
    cond = 4'b0000; #1;
    chk("rst_cond_eq", {31'd0, cond_pass}, 32'h0);
    edge_();

    // Basic write then read
    wr_en = 1; wr_addr = 3; wr_data = 32'h0000_FFFF; cond = 4'b1110;
    cyc();
    wr_en = 0; ra_addr = 3;
    settle();
    chk("wr_r3", a_out, 32'h0000_FFFF);
    chk("wr_count1", {16'd0, commit_count}, 32'd1);
    edge_();

    // Same-cycle bypass on both ports
    wr_en = 1; wr_addr = 5; wr_data = 32'hF0F0_F0F0; ra_addr = 5; rb_addr = 5;
    settle();
    chk("byp_a", a_out, 32'hF0F0_F0F0);
    chk("byp_b", b_out, 32'hF0F0_F0F0);
    edge_();

    // Flag load and condition evaluation
    wr_en = 0; set_flags = 1; nzcv_in = 4'b0110; cond = 4'b1110;
    cyc();
    set_flags = 0; cond = 4'b0000;
    settle();
    chk("flg_0110", {28'd0, flags_out}, 32'h6);
    chk("flg_carry", {31'd0, carry_out}, 32'h1);
    chk("flg_eq", {31'd0, cond_pass}, 32'h1);
    cond = 4'b1000; #1;
    chk("flg_hi", {31'd0, cond_pass}, 32'h0);
    edge_();

    // Suppressed write
    set_flags = 1; nzcv_in = 4'b0100; cond = 4'b1110;
    cyc();
    set_flags = 0; wr_en = 1; wr_addr = 2; wr_data = 32'hFFFF_FFFF; cond = 4'b0001;
    ra_addr = 2;
    settle();
    chk("sup_pass", {31'd0, cond_pass}, 32'h0);
    chk("sup_nobyp", a_out, 32'h0);
    edge_();
    wr_en = 0;
    settle();
    chk("sup_r2", a_out, 32'h0);
    chk("sup_count", {16'd0, commit_count}, 32'd2);
    edge_();

    // Condition sees flags before the edge, not nzcv_in
    set_flags = 1; nzcv_in = 4'b0000; cond = 4'b1110;
    cyc();
    nzcv_in = 4'b0100; cond = 4'b0000;
    settle();
    chk("old_pass", {31'd0, cond_pass}, 32'h0);
    edge_();
    set_flags = 0;
    settle();
    chk("old_flags", {28'd0, flags_out}, 32'h0);
    edge_();
    set_flags = 1; nzcv_in = 4'b1111; wr_en = 1; wr_addr = 2; wr_data = 32'h1234;
    cond = 4'b1111;
    settle();
    chk("nv_pass", {31'd0, cond_pass}, 32'h0);
    edge_();
    set_flags = 0; wr_en = 0;
    settle();
    chk("nv_flags", {28'd0, flags_out}, 32'h0);
    chk("nv_r2", a_out, 32'h0);
    chk("nv_count", {16'd0, commit_count}, 32'd2);
    edge_();

    // Write and flag update together, register 0 is writable
    wr_en = 1; set_flags = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF; nzcv_in = 4'b1001;
    cond = 4'b1110;
    cyc();
    wr_en = 0; set_flags = 0; ra_addr = 0; rb_addr = 5;
    settle();
    chk("both_r0", a_out, 32'hDEAD_BEEF);
    chk("both_r5", b_out, 32'hF0F0_F0F0);
    chk("both_flags", {28'd0, flags_out}, 32'h9);
    chk("both_count", {16'd0, commit_count}, 32'd3);
    edge_();

    // Sweep every condition over every flag pattern
    for (int f = 0; f < 16; f++) begin
      set_flags = 1; nzcv_in = 4'(f); cond = 4'b1110;
      cyc();
      set_flags = 0;
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        cyc();
      end
    end

    // Counter wrap: 65533 more writes reach 65536 total, then 3 more
    wr_en = 1; cond = 4'b1110;
    for (int i = 0; i < 65533; i++) begin
      wr_addr = 4'(i); wr_data = i * 32'h9E37_79B9; ra_addr = 4'(i + 1); rb_addr = 4'(i);
      cyc();
    end
    wr_en = 0;
    settle();
    chk("wrap_zero", {16'd0, commit_count}, 32'd0);
    edge_();
    wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 4'(i); wr_data = 32'hA5A5_0000 + i;
      cyc();
    end
    wr_en = 0;
    settle();
    chk("wrap_three", {16'd0, commit_count}, 32'd3);
    edge_();

    // Reset overrides pending write and flag update
    set_flags = 1; nzcv_in = 4'b1111; cond = 4'b1110;
    cyc();
    reset = 1; wr_en = 1; wr_addr = 7; wr_data = 32'h7777_7777; nzcv_in = 4'b1010;
    cyc();
    reset = 0; wr_en = 0; set_flags = 0;
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i); rb_addr = 4'(15 - i);
      settle();
      chk("rst2_reg", a_out, 32'h0);
      edge_();
    end
    settle();
    chk("rst2_flags", {28'd0, flags_out}, 32'h0);
    chk("rst2_carry", {31'd0, carry_out}, 32'h0);
    chk("rst2_count", {16'd0, commit_count}, 32'h0);
    edge_();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_nzcv.md
REGFILE_NZCV -- requirements
Module: regfile_nzcv

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, operand/result width; ADDR_W, 4, register address width (2^ADDR_W = 16 registers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 ra_addr  input  ADDR_W  read-port A register select.
REQ-005 rb_addr  input  ADDR_W  read-port B register select.
REQ-006 a_out  output  DATA_W  operand A to the ALU a input.
REQ-007 b_out  output  DATA_W  operand B to the ALU b input.
REQ-008 wr_en  input  1  request to write ALU result to wr_addr.
REQ-009 wr_addr  input  ADDR_W  destination register.
REQ-010 wr_data  input  DATA_W  ALU result.
REQ-011 set_flags  input  1  request to latch nzcv_in into the status register.
REQ-012 nzcv_in  input  4  ALU flags; bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-013 cond  input  4  condition code gating this cycle's write and flag update.
REQ-014 cond_pass  output  1  combinational result of evaluating cond against stored flags.
REQ-015 flags_out  output  4  stored NZCV, same bit order as nzcv_in.
REQ-016 carry_out  output  1  stored C flag (flags_out[1]), drives the ALU carry input.
REQ-017 commit_count  output  16  count of committed register writes.

Function
REQ-018 Reads SHALL be combinational from 16 x DATA_W registers; no read latency.
REQ-019 Same-cycle bypass: if a register write commits this cycle and ra_addr (or rb_addr) equals wr_addr, a_out (or b_out) SHALL present wr_data rather than the stored value.
REQ-020 cond_pass SHALL decode from stored flags: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1 (always); 1111 0 (never).
REQ-021 A register write SHALL commit at the rising edge iff wr_en & cond_pass & !reset; committed value = wr_data, full DATA_W, no truncation.
REQ-022 The flag register SHALL load nzcv_in at the rising edge iff set_flags & cond_pass & !reset; otherwise it holds.
REQ-023 cond SHALL evaluate against flags stored before the edge, never against nzcv_in of the same cycle (an instruction setting and testing flags sees old flags).
REQ-024 Register write and flag update in the same cycle SHALL both take effect independently.
REQ-025 commit_count SHALL increment by 1 at each committed register write, wrap 16'hFFFF -> 16'h0000, and not count suppressed writes or flag-only updates.
REQ-026 All registers, including address 0, SHALL be writable general-purpose registers; no hard-wired zero.
REQ-027 carry_out SHALL equal flags_out[1] at all times.

Reset
REQ-028 While reset is high at a rising edge: all 16 registers <= 0, flags <= 4'b0000, commit_count <= 0; writes and flag updates that cycle are discarded.
REQ-029 Post-reset outputs: a_out = b_out = 0 (absent bypass), flags_out = 0, carry_out = 0, commit_count = 0; cond_pass follows REQ-020 on zero flags (e.g. cond=0001 -> 1, cond=0000 -> 0).
REQ-030 Reset asserted mid-sequence SHALL override any pending wr_en/set_flags at that edge; state is not retained.

Verification
REQ-031 Reset, then wr_en=1, wr_addr=3, wr_data=32'h0000_FFFF, cond=1110 -> after edge ra_addr=3 gives a_out=32'h0000_FFFF, commit_count=1.
REQ-032 Bypass: wr_en=1, wr_addr=5, wr_data=32'hF0F0_F0F0, cond=1110, ra_addr=rb_addr=5 in the same cycle -> a_out=b_out=32'hF0F0_F0F0 before the edge.
REQ-033 set_flags=1, nzcv_in=4'b0110 (Z,C), cond=1110 -> flags_out=4'b0110, carry_out=1; then cond=0000 -> cond_pass=1, cond=1000 -> cond_pass=0.
REQ-034 Suppressed write: flags=4'b0100, wr_en=1, wr_addr=2, wr_data=32'hFFFF_FFFF, cond=0001 -> cond_pass=0, R2 unchanged, commit_count unchanged.
REQ-035 Flags-before-edge: flags=0000, set_flags=1, nzcv_in=4'b0100, cond=0000 -> cond_pass=0, flags remain 0000; repeat with cond=1111 -> no write or flag change.
REQ-036 Wrap and reset: 65536 committed writes -> commit_count=0; reset asserted with wr_en=1, cond=1110 -> all registers, flags and count read 0 afterward.
